// File: rtl/mem_wb_stage_if.sv
// Data-memory request/acknowledge port between the MEM stage (master) and the data memory (slave).
interface mem_wb_stage_if #(
    parameter int DATA_W = 32
);
    logic              dmem_req;
    logic              dmem_we;
    logic [DATA_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic [DATA_W-1:0] dmem_rdata;
    logic              dmem_ack;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_wdata,
        input  dmem_rdata,
        input  dmem_ack
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_wdata,
        output dmem_rdata,
        output dmem_ack
    );
endinterface

// File: rtl/mem_wb_stage.sv
// Memory-access stage and MEM/WB register: issues loads/stores over a req/ack port with wait states,
// stalls upstream while an access is in flight, and drops misaligned or timed-out accesses.
module mem_wb_stage #(
    parameter int DATA_W  = 32,
    parameter int REG_W   = 5,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Reg_Write_M,
    input  logic              MemToReg_M,
    input  logic              Mem_Write_M,
    input  logic [DATA_W-1:0] ALU_Out_M,
    input  logic [DATA_W-1:0] Write_Data_M,
    input  logic [REG_W-1:0]  Write_Reg_M,
    mem_wb_stage_if.master    dmem,
    output logic              Stall_M,
    output logic              Mem_Err,
    output logic              Reg_Write_W,
    output logic              MemToReg_W,
    output logic [DATA_W-1:0] Read_Data_W,
    output logic [DATA_W-1:0] ALU_Out_W,
    output logic [REG_W-1:0]  Write_Reg_W
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic              reg_write_w_q, reg_write_w_d;
    logic              mem_to_reg_w_q, mem_to_reg_w_d;
    logic [DATA_W-1:0] read_data_w_q, read_data_w_d;
    logic [DATA_W-1:0] alu_out_w_q, alu_out_w_d;
    logic [REG_W-1:0]  write_reg_w_q, write_reg_w_d;

    logic access;
    logic misal;
    logic stall_c;
    logic err_c;

    assign access = MemToReg_M | Mem_Write_M;
    assign misal  = access & (ALU_Out_M[1:0] != 2'b00);

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        req_d          = req_q;
        we_d           = we_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        // MEM/WB loads a bubble unless an instruction retires this cycle
        reg_write_w_d  = 1'b0;
        mem_to_reg_w_d = 1'b0;
        read_data_w_d  = '0;
        alu_out_w_d    = '0;
        write_reg_w_d  = '0;
        stall_c        = 1'b0;
        err_c          = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!access) begin
                    reg_write_w_d  = Reg_Write_M;
                    mem_to_reg_w_d = MemToReg_M;
                    alu_out_w_d    = ALU_Out_M;
                    write_reg_w_d  = Write_Reg_M;
                end else if (misal) begin
                    err_c = 1'b1;
                end else begin
                    stall_c = 1'b1;
                    state_d = S_WAIT;
                    cnt_d   = '0;
                    req_d   = 1'b1;
                    we_d    = Mem_Write_M;
                    addr_d  = ALU_Out_M;
                    wdata_d = Write_Data_M;
                end
            end
            S_WAIT: begin
                // Upstream is held, so the *_M inputs still describe the in-flight instruction
                if (dmem.dmem_ack) begin
                    reg_write_w_d  = Reg_Write_M;
                    mem_to_reg_w_d = MemToReg_M;
                    read_data_w_d  = Mem_Write_M ? '0 : dmem.dmem_rdata;
                    alu_out_w_d    = ALU_Out_M;
                    write_reg_w_d  = Write_Reg_M;
                    req_d          = 1'b0;
                    state_d        = S_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    err_c   = 1'b1;
                    req_d   = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    stall_c = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            req_q          <= 1'b0;
            we_q           <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            reg_write_w_q  <= 1'b0;
            mem_to_reg_w_q <= 1'b0;
            read_data_w_q  <= '0;
            alu_out_w_q    <= '0;
            write_reg_w_q  <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            req_q          <= req_d;
            we_q           <= we_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            reg_write_w_q  <= reg_write_w_d;
            mem_to_reg_w_q <= mem_to_reg_w_d;
            read_data_w_q  <= read_data_w_d;
            alu_out_w_q    <= alu_out_w_d;
            write_reg_w_q  <= write_reg_w_d;
        end
    end

    // Combinational outputs are forced low while reset is asserted
    assign Stall_M = rst & stall_c;
    assign Mem_Err = rst & err_c;

    assign dmem.dmem_req   = req_q;
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_wdata = wdata_q;

    assign Reg_Write_W = reg_write_w_q;
    assign MemToReg_W  = mem_to_reg_w_q;
    assign Read_Data_W = read_data_w_q;
    assign ALU_Out_W   = alu_out_w_q;
    assign Write_Reg_W = write_reg_w_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: the bench plays the data memory and checks against hand-computed values.
module tb_mem_wb_stage;

    logic        clk;
    logic        rst;
    logic        Reg_Write_M, MemToReg_M, Mem_Write_M;
    logic [31:0] ALU_Out_M, Write_Data_M;
    logic [4:0]  Write_Reg_M;
    logic        Stall_M, Mem_Err;
    logic        Reg_Write_W, MemToReg_W;
    logic [31:0] Read_Data_W, ALU_Out_W;
    logic [4:0]  Write_Reg_W;

    int total = 0;
    int bad   = 0;
    int nstall;

    mem_wb_stage_if #(.DATA_W(32)) mif ();

    mem_wb_stage #(.DATA_W(32), .REG_W(5), .TIMEOUT(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .Reg_Write_M  (Reg_Write_M),
        .MemToReg_M   (MemToReg_M),
        .Mem_Write_M  (Mem_Write_M),
        .ALU_Out_M    (ALU_Out_M),
        .Write_Data_M (Write_Data_M),
        .Write_Reg_M  (Write_Reg_M),
        .dmem         (mif.master),
        .Stall_M      (Stall_M),
        .Mem_Err      (Mem_Err),
        .Reg_Write_W  (Reg_Write_W),
        .MemToReg_W   (MemToReg_W),
        .Read_Data_W  (Read_Data_W),
        .ALU_Out_W    (ALU_Out_W),
        .Write_Reg_W  (Write_Reg_W)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input logic rw, input logic m2r, input logic mw,
                         input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] wr);
        Reg_Write_M  = rw;
        MemToReg_M   = m2r;
        Mem_Write_M  = mw;
        ALU_Out_M    = alu;
        Write_Data_M = wd;
        Write_Reg_M  = wr;
    endtask

    task automatic chk_w(input string tag, input logic rw, input logic m2r,
                         input logic [31:0] rd, input logic [31:0] alu, input logic [4:0] wr);
        chk({tag, ".Reg_Write_W"}, 64'(Reg_Write_W), 64'(rw));
        chk({tag, ".MemToReg_W"},  64'(MemToReg_W),  64'(m2r));
        chk({tag, ".Read_Data_W"}, 64'(Read_Data_W), 64'(rd));
        chk({tag, ".ALU_Out_W"},   64'(ALU_Out_W),   64'(alu));
        chk({tag, ".Write_Reg_W"}, 64'(Write_Reg_W), 64'(wr));
    endtask

    initial begin
        rst          = 1'b0;
        mif.dmem_ack   = 1'b0;
        mif.dmem_rdata = 32'h0;
        set_m(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);

        // reset state
        #12;
        chk("rst.req", 64'(mif.dmem_req), 64'd0);
        chk("rst.we", 64'(mif.dmem_we), 64'd0);
        chk("rst.addr", 64'(mif.dmem_addr), 64'd0);
        chk("rst.stall", 64'(Stall_M), 64'd0);
        chk("rst.err", 64'(Mem_Err), 64'd0);
        chk_w("rst", 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        step();
        rst = 1'b1;

        // 1: ALU op flows through with latency 1
        set_m(1'b1, 1'b0, 1'b0, 32'h1234, 32'h0, 5'd5);
        #1;
        chk("alu.stall", 64'(Stall_M), 64'd0);
        step();
        chk_w("alu", 1'b1, 1'b0, 32'h0, 32'h1234, 5'd5);
        chk("alu.req", 64'(mif.dmem_req), 64'd0);

        // 2: load, ack on the 4th WAIT cycle
        set_m(1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 5'd7);
        nstall = 0;
        #1;
        if (Stall_M) nstall++;
        chk("ld.req0", 64'(mif.dmem_req), 64'd0);
        step();
        chk("ld.req", 64'(mif.dmem_req), 64'd1);
        chk("ld.we", 64'(mif.dmem_we), 64'd0);
        chk("ld.addr", 64'(mif.dmem_addr), 64'h40);
        for (int i = 1; i < 4; i++) begin
            #1;
            if (Stall_M) nstall++;
            chk("ld.bubble", 64'(Reg_Write_W), 64'd0);
            chk("ld.req_hold", 64'(mif.dmem_req), 64'd1);
            step();
        end
        mif.dmem_ack   = 1'b1;
        mif.dmem_rdata = 32'hDEADBEEF;
        #1;
        if (Stall_M) nstall++;
        chk("ld.stall_count", 64'(nstall), 64'd4);
        step();
        mif.dmem_ack   = 1'b0;
        mif.dmem_rdata = 32'h0;
        chk_w("ld", 1'b1, 1'b1, 32'hDEADBEEF, 32'h40, 5'd7);
        chk("ld.req_fall", 64'(mif.dmem_req), 64'd0);

        // 3: store, ack in the first WAIT cycle
        set_m(1'b0, 1'b0, 1'b1, 32'h44, 32'hA5A5A5A5, 5'd0);
        #1;
        chk("st.stall0", 64'(Stall_M), 64'd1);
        step();
        chk("st.we", 64'(mif.dmem_we), 64'd1);
        chk("st.wdata", 64'(mif.dmem_wdata), 64'hA5A5A5A5);
        chk("st.addr", 64'(mif.dmem_addr), 64'h44);
        mif.dmem_ack = 1'b1;
        #1;
        chk("st.stall1", 64'(Stall_M), 64'd0);
        step();
        mif.dmem_ack = 1'b0;
        chk_w("st", 1'b0, 1'b0, 32'h0, 32'h44, 5'd0);
        chk("st.req_fall", 64'(mif.dmem_req), 64'd0);

        // 4: misaligned load
        set_m(1'b1, 1'b1, 1'b0, 32'h42, 32'h0, 5'd6);
        #1;
        chk("mis.err", 64'(Mem_Err), 64'd1);
        chk("mis.stall", 64'(Stall_M), 64'd0);
        step();
        chk("mis.req", 64'(mif.dmem_req), 64'd0);
        chk_w("mis", 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        set_m(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        #1;
        chk("mis.err_pulse", 64'(Mem_Err), 64'd0);

        // 5a: load timeout after 4 WAIT cycles
        set_m(1'b1, 1'b1, 1'b0, 32'h48, 32'h0, 5'd8);
        step();
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("to.stall", 64'(Stall_M), 64'd1);
            chk("to.noerr", 64'(Mem_Err), 64'd0);
            step();
        end
        #1;
        chk("to.err", 64'(Mem_Err), 64'd1);
        chk("to.stall_last", 64'(Stall_M), 64'd0);
        step();
        set_m(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        chk("to.req_fall", 64'(mif.dmem_req), 64'd0);
        chk_w("to", 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        #1;
        chk("to.err_pulse", 64'(Mem_Err), 64'd0);

        // 5b: ack in the last WAIT cycle wins over timeout
        set_m(1'b1, 1'b1, 1'b0, 32'h4C, 32'h0, 5'd9);
        step();
        step();
        step();
        step();
        mif.dmem_ack   = 1'b1;
        mif.dmem_rdata = 32'h0BADF00D;
        #1;
        chk("late.err", 64'(Mem_Err), 64'd0);
        chk("late.stall", 64'(Stall_M), 64'd0);
        step();
        mif.dmem_ack   = 1'b0;
        mif.dmem_rdata = 32'h0;
        chk_w("late", 1'b1, 1'b1, 32'h0BADF00D, 32'h4C, 5'd9);

        // ack while IDLE is ignored
        set_m(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        mif.dmem_ack   = 1'b1;
        mif.dmem_rdata = 32'hFFFFFFFF;
        step();
        mif.dmem_ack   = 1'b0;
        mif.dmem_rdata = 32'h0;
        chk("idleack.req", 64'(mif.dmem_req), 64'd0);
        chk("idleack.rd", 64'(Read_Data_W), 64'd0);

        // MemToReg and Mem_Write both set: behaves as a store
        set_m(1'b1, 1'b1, 1'b1, 32'h60, 32'h11, 5'd4);
        step();
        chk("both.we", 64'(mif.dmem_we), 64'd1);
        chk("both.wdata", 64'(mif.dmem_wdata), 64'h11);
        mif.dmem_ack   = 1'b1;
        mif.dmem_rdata = 32'h12345678;
        step();
        mif.dmem_ack   = 1'b0;
        mif.dmem_rdata = 32'h0;
        chk_w("both", 1'b1, 1'b1, 32'h0, 32'h60, 5'd4);

        // 6: asynchronous reset mid-WAIT
        set_m(1'b1, 1'b1, 1'b0, 32'h50, 32'h0, 5'd3);
        step();
        step();
        chk("arst.req_before", 64'(mif.dmem_req), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst.req", 64'(mif.dmem_req), 64'd0);
        chk("arst.stall", 64'(Stall_M), 64'd0);
        chk("arst.err", 64'(Mem_Err), 64'd0);
        chk_w("arst", 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        set_m(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        step();
        rst = 1'b1;
        set_m(1'b1, 1'b0, 1'b0, 32'h77, 32'h0, 5'd3);
        #1;
        chk("post.stall", 64'(Stall_M), 64'd0);
        step();
        chk_w("post", 1'b1, 1'b0, 32'h0, 32'h77, 5'd3);
        chk("post.req", 64'(mif.dmem_req), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
